datapath: RTL

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_if.sv | 36 +++
 rtl/datapath.sv | 135 +++++++++++++
 2 files changed

// File: rtl/datapath_if.sv
// Control/status bundle between the accumulator datapath and its control unit.
// Program memory is external, so prog_data is driven by the master side.
interface datapath_if #(
    parameter int unsigned DATA_W = 8
);
    logic              pc_inc;
    logic              pc_load;
    logic              ir_load;
    logic              regA_load;
    logic              regR0_load;
    logic              regR1_load;
    logic [1:0]        alu_op;
    logic              output_enable;
    logic              halt;
    logic [7:0]        prog_data;

    logic [3:0]        prog_addr;
    logic [3:0]        opcode;
    logic              zero;
    logic              carry;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [DATA_W-1:0] acc;

    modport master (
        output pc_inc, pc_load, ir_load, regA_load, regR0_load, regR1_load,
               alu_op, output_enable, halt, prog_data,
        input  prog_addr, opcode, zero, carry, out_data, out_valid, acc
    );

    modport slave (
        input  pc_inc, pc_load, ir_load, regA_load, regR0_load, regR1_load,
               alu_op, output_enable, halt, prog_data,
        output prog_addr, opcode, zero, carry, out_data, out_valid, acc
    );
endinterface

// File: rtl/datapath.sv
// Accumulator datapath: 4-bit PC, 8-bit IR, A/R0/R1 registers, 2-bit ALU with
// registered zero/carry flags, and a strobed output register.
module datapath #(
    parameter int unsigned DATA_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    datapath_if.slave dp
);
    localparam int unsigned PC_W  = 4;
    localparam int unsigned IR_W  = 8;
    localparam int unsigned SUM_W = DATA_W + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] operand;
    logic [SUM_W-1:0]  sum_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W-1:0] imm_ext;

    // ALU: IR[6] picks R1 over R0 as the second operand
    always_comb begin
        operand   = ir_q[6] ? r1_q : r0_q;
        sum_w     = SUM_W'(a_q) + SUM_W'(operand);
        alu_res   = '0;
        alu_carry = 1'b0;
        case (dp.alu_op)
            OP_ADD: begin
                alu_res   = sum_w[DATA_W-1:0];
                alu_carry = sum_w[DATA_W];
            end
            OP_SUB: begin
                alu_res   = a_q - operand;
                alu_carry = (a_q < operand);
            end
            OP_AND: alu_res = a_q & operand;
            OP_XOR: alu_res = a_q ^ operand;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    assign imm_ext = DATA_W'(ir_q[3:0]);

    // Next-state: every load consumes pre-edge values; halt freezes everything
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        if (!dp.halt) begin
            if (dp.pc_load) begin
                pc_d = ir_q[3:0];
            end else if (dp.pc_inc) begin
                pc_d = pc_q + PC_W'(1);
            end

            if (dp.ir_load) begin
                ir_d = dp.prog_data;
            end
            if (dp.regR0_load) begin
                r0_d = imm_ext;
            end
            if (dp.regR1_load) begin
                r1_d = imm_ext;
            end

            if (dp.regA_load) begin
                a_d     = alu_res;
                carry_d = alu_carry;
                zero_d  = (alu_res == '0);
            end

            if (dp.output_enable) begin
                out_d       = a_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dp.prog_addr = pc_q;
    assign dp.opcode    = ir_q[7:4];
    assign dp.zero      = zero_q;
    assign dp.carry     = carry_q;
    assign dp.out_data  = out_q;
    assign dp.out_valid = out_valid_q;
    assign dp.acc       = a_q;

endmodule
